// File: rtl/wb_pkg.sv
// Writeback arbiter shared types.
// Request bundle carried from producers to the regfile port.
package wb_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small writeback result FIFO.
// Full/empty derive from a count; pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_push,
  input  wb_req_t i_din,
  input  logic    i_pop,
  output wb_req_t o_dout,
  output logic    o_full,
  output logic    o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign o_dout  = mem[rd_ptr];

  // Storage array; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr] <= i_din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter owning the register file write port.
// ALU/LSU results are buffered, arbitrated, and registered out.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_alu_valid,
  output logic        o_alu_ready,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic [4:0]  i_lsu_rd,
  input  logic [31:0] i_lsu_data,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_busy
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic    alu_full, alu_empty, lsu_full, lsu_empty;
  logic    alu_push, lsu_push;
  logic    grant_alu, grant_lsu;
  wb_req_t alu_head, lsu_head, win;
  logic [SW-1:0] starve_cnt;

  assign o_alu_ready = !alu_full && !i_reset;
  assign o_lsu_ready = !lsu_full && !i_reset;

  // Writes to x0 complete the handshake but are dropped.
  assign alu_push = i_alu_valid && o_alu_ready && (i_alu_rd != '0);
  assign lsu_push = i_lsu_valid && o_lsu_ready && (i_lsu_rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (alu_push),
    .i_din   ('{rd: i_alu_rd, data: i_alu_data}),
    .i_pop   (grant_alu),
    .o_dout  (alu_head),
    .o_full  (alu_full),
    .o_empty (alu_empty)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (lsu_push),
    .i_din   ('{rd: i_lsu_rd, data: i_lsu_data}),
    .i_pop   (grant_lsu),
    .o_dout  (lsu_head),
    .o_full  (lsu_full),
    .o_empty (lsu_empty)
  );

  // LSU-favoured grant with a bounded starvation window for ALU.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    win       = lsu_head;
    if (!alu_empty &&
        (lsu_empty || starve_cnt == SW'(STARVE_MAX))) begin
      grant_alu = 1'b1;
      win       = alu_head;
    end else if (!lsu_empty) begin
      grant_lsu = 1'b1;
    end
  end

  // Count LSU wins while ALU waits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      starve_cnt <= '0;
    end else if (alu_empty || grant_alu) begin
      starve_cnt <= '0;
    end else if (grant_lsu) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered regfile write; addr/data hold when idle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= grant_alu || grant_lsu;
      if (grant_alu || grant_lsu) begin
        o_rd_addr <= win.rd;
        o_rd_data <= win.data;
      end
    end
  end

  assign o_busy = !alu_empty || !lsu_empty || o_rd_wren;
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter.
// Scoreboard of expected regfile writes, checked at each write.
module tb_wb_arbiter;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_alu_valid;
  logic        o_alu_ready;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  wb_arbiter #(.DEPTH(2), .STARVE_MAX(2)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_alu_valid (i_alu_valid),
    .o_alu_ready (o_alu_ready),
    .i_alu_rd    (i_alu_rd),
    .i_alu_data  (i_alu_data),
    .i_lsu_valid (i_lsu_valid),
    .o_lsu_ready (o_lsu_ready),
    .i_lsu_rd    (i_lsu_rd),
    .i_lsu_data  (i_lsu_data),
    .o_rd_wren   (o_rd_wren),
    .o_rd_addr   (o_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Write monitor: every write must match the scoreboard head.
  always @(negedge i_clk) begin
    if (mon_en && !i_reset && o_rd_wren) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got rd=%0d data=%h, none expected",
                 o_rd_addr, o_rd_data);
      end else begin
        e = exp_q.pop_front();
        if (o_rd_addr !== e.rd || o_rd_data !== e.data) begin
          errors++;
          $display("FAIL write_order got rd=%0d data=%h want rd=%0d data=%h",
                   o_rd_addr, o_rd_data, e.rd, e.data);
        end
      end
    end
  end

  function automatic void expect_wr(input logic [4:0] rd,
                                    input logic [31:0] d);
    exp_t e;
    e.rd = rd;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic alu_send(input logic [4:0] rd, input logic [31:0] d);
    int n = 0;
    logic rdy;
    i_alu_valid = 1'b1;
    i_alu_rd = rd;
    i_alu_data = d;
    do begin
      rdy = o_alu_ready;
      @(negedge i_clk);
      n++;
    end while (!rdy && n < 60);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL alu_accept_timeout rd=%0d got no ready, want ready", rd);
    end
  endtask

  task automatic lsu_send(input logic [4:0] rd, input logic [31:0] d);
    int n = 0;
    logic rdy;
    i_lsu_valid = 1'b1;
    i_lsu_rd = rd;
    i_lsu_data = d;
    do begin
      rdy = o_lsu_ready;
      @(negedge i_clk);
      n++;
    end while (!rdy && n < 60);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL lsu_accept_timeout rd=%0d got no ready, want ready", rd);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout busy=%b want 0", o_busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lost_writes pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_alu_valid = 1'b0;
    i_alu_rd = '0;
    i_alu_data = '0;
    i_lsu_valid = 1'b0;
    i_lsu_rd = '0;
    i_lsu_data = '0;
    #1;
    checks++;
    if ({o_rd_wren, o_rd_addr, o_rd_data, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wren=%b addr=%0d data=%h busy=%b want 0",
               o_rd_wren, o_rd_addr, o_rd_data, o_busy);
    end
    checks++;
    if ({o_alu_ready, o_lsu_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 00", o_alu_ready, o_lsu_ready);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    checks++;
    if ({o_alu_ready, o_lsu_ready} !== 2'b11) begin
      errors++;
      $display("FAIL release_ready got %b%b want 11", o_alu_ready, o_lsu_ready);
    end
    @(negedge i_clk);
  endtask

  task automatic test_single_alu();
    expect_wr(5'd5, 32'hDEADBEEF);
    alu_send(5'd5, 32'hDEADBEEF);
    i_alu_valid = 1'b0;
    checks++;
    if (o_rd_wren !== 1'b0) begin
      errors++;
      $display("FAIL single_t1_wren got %b want 0", o_rd_wren);
    end
    @(negedge i_clk);
    checks++;
    if (o_rd_wren !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_t2 got wren=%b busy=%b want 1 1",
               o_rd_wren, o_busy);
    end
    @(negedge i_clk);
    checks++;
    if (o_rd_wren !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_t3 got wren=%b busy=%b want 0 0",
               o_rd_wren, o_busy);
    end
    wait_idle();
  endtask

  task automatic test_x0_filter();
    lsu_send(5'd0, 32'h12345678);
    i_lsu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_rd_wren !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL x0_filter cyc%0d got wren=%b busy=%b want 0 0",
                 k, o_rd_wren, o_busy);
      end
      @(negedge i_clk);
    end
    wait_idle();
  endtask

  task automatic test_burst();
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (o_rd_wren !== ((k >= 2 && k <= 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL burst_wren cyc t+%0d got %b want %b", k, o_rd_wren,
                 (k >= 2 && k <= 5));
      end
      if (k < 4) begin
        checks++;
        if (o_alu_ready !== 1'b1) begin
          errors++;
          $display("FAIL burst_ready cyc t+%0d got 0 want 1", k);
        end
        i_alu_valid = 1'b1;
        i_alu_rd = 5'(6 + k);
        i_alu_data = 32'(16 + k);
        expect_wr(5'(6 + k), 32'(16 + k));
      end else begin
        i_alu_valid = 1'b0;
      end
      @(negedge i_clk);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    for (int g = 0; g < 3; g++) begin
      expect_wr(5'(17 + 2 * g), 32'hB000_0000 + 32'(17 + 2 * g));
      expect_wr(5'(18 + 2 * g), 32'hB000_0000 + 32'(18 + 2 * g));
      expect_wr(5'(3 + g), 32'hA000_0000 + 32'(3 + g));
    end
    expect_wr(5'd23, 32'hB000_0000 + 32'd23);
    expect_wr(5'd24, 32'hB000_0000 + 32'd24);
    fork
      begin
        for (int i = 17; i <= 24; i++)
          lsu_send(5'(i), 32'hB000_0000 + 32'(i));
        i_lsu_valid = 1'b0;
      end
      begin
        alu_send(5'd3, 32'hA000_0003);
        alu_send(5'd4, 32'hA000_0004);
        checks++;
        if (o_alu_ready !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_ready got %b want 0", o_alu_ready);
        end
        alu_send(5'd5, 32'hA000_0005);
        i_alu_valid = 1'b0;
      end
    join
    wait_idle();
  endtask

  task automatic test_saturation();
    for (int g = 0; g < 6; g++) begin
      expect_wr(5'(17 + 2 * g), 32'hB000_0000 + 32'(17 + 2 * g));
      expect_wr(5'(18 + 2 * g), 32'hB000_0000 + 32'(18 + 2 * g));
      expect_wr(5'(1 + g), 32'hA000_0000 + 32'(1 + g));
    end
    for (int i = 7; i <= 12; i++)
      expect_wr(5'(i), 32'hA000_0000 + 32'(i));
    fork
      begin
        for (int i = 1; i <= 12; i++)
          alu_send(5'(i), 32'hA000_0000 + 32'(i));
        i_alu_valid = 1'b0;
      end
      begin
        for (int i = 17; i <= 28; i++)
          lsu_send(5'(i), 32'hB000_0000 + 32'(i));
        i_lsu_valid = 1'b0;
      end
    join
    wait_idle();
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0;
    i_alu_valid = 1'b1;
    i_alu_rd = 5'd10;
    i_alu_data = 32'h0000_0A0A;
    i_lsu_valid = 1'b1;
    i_lsu_rd = 5'd20;
    i_lsu_data = 32'h0000_1414;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1 || o_rd_wren !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got busy=%b wren=%b want 1 1", o_busy, o_rd_wren);
    end
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_rd_wren, o_rd_addr, o_rd_data, o_busy,
         o_alu_ready, o_lsu_ready} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got wren=%b addr=%0d data=%h busy=%b rdy=%b%b want 0",
               o_rd_wren, o_rd_addr, o_rd_data, o_busy,
               o_alu_ready, o_lsu_ready);
    end
    i_alu_valid = 1'b0;
    i_lsu_valid = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    checks++;
    if ({o_alu_ready, o_lsu_ready} !== 2'b11) begin
      errors++;
      $display("FAIL mid_release_ready got %b%b want 11",
               o_alu_ready, o_lsu_ready);
    end
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      checks++;
      if (o_rd_wren !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_write cyc%0d got wren=%b busy=%b want 0 0",
                 k, o_rd_wren, o_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_x0_filter();
    test_burst();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that owns the register file write port. It accepts completed results from two producers, the single-cycle ALU and the multi-cycle LSU, buffers each in its own small FIFO, and picks one result per cycle. The chosen result goes out as a registered write (`rd_wren`/`rd_addr`/`rd_data`) into the 32x32 register file. Writes to x0 are discarded here, so the register file never stores to x0.

## Interface
- `DEPTH`, 2: entries per source FIFO; must be a power of 2, ≥2.
- `STARVE_MAX`, 2: consecutive LSU grants allowed while ALU is pending.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_alu_valid`  in  1  ALU result valid.
- `o_alu_ready`  out  1  ALU FIFO can accept.
- `i_alu_rd`  in  5  ALU destination register.
- `i_alu_data`  in  32  ALU result.
- `i_lsu_valid`  in  1  LSU result valid.
- `o_lsu_ready`  out  1  LSU FIFO can accept.
- `i_lsu_rd`  in  5  LSU destination register.
- `i_lsu_data`  in  32  LSU load data.
- `o_rd_wren`  out  1  register file write enable.
- `o_rd_addr`  out  5  register file write address.
- `o_rd_data`  out  32  register file write data.
- `o_busy`  out  1  any result is buffered or being written.

## Operation
- **Handshake:** a transfer occurs when valid && ready on a source at a rising edge. Producers hold rd/data stable while valid && !ready.
- **Ready:** `o_x_ready = !full_x && !i_reset`.
  - Depends only on the FIFO count, never on valid or on a same-cycle pop.
  - A full FIFO therefore stays not-ready even in a cycle where it is popped.
- **x0 filter:** an accepted transfer with rd==0 completes the handshake but is not enqueued. It produces no write.
- **Arbitration:** every cycle with at least one FIFO non-empty, exactly one entry is popped.
  - Grant ALU if the LSU FIFO is empty, or if the ALU FIFO is non-empty and `starve_cnt == STARVE_MAX`.
  - Otherwise grant LSU.
- **`starve_cnt` update:**
  - +1 on an LSU grant while the ALU FIFO is non-empty.
  - Cleared on an ALU grant.
  - Cleared whenever the ALU FIFO is empty.
  - Width is `$clog2(STARVE_MAX+1)`; it never exceeds `STARVE_MAX`.
- **Output register:** the popped entry is loaded into `o_rd_addr`/`o_rd_data` with `o_rd_wren=1`. In a cycle with no grant, `o_rd_wren` goes to 0 and addr/data hold their last values.
- **Ordering:**
  - Within one source, writes retire in acceptance order.
  - Across sources, order is not guaranteed. Issue logic guarantees no two in-flight results target the same rd.
- **Busy:** `o_busy = !empty_alu || !empty_lsu || o_rd_wren`.
- **Reset:** asynchronous. FIFOs are emptied (pointers and counts 0), `starve_cnt=0`, and `o_rd_wren=0`, `o_rd_addr=0`, `o_rd_data=0`.
  - Both readies are 0 while reset is asserted and 1 in the first cycle after release.
  - Reset mid-operation drops all buffered results. No write is issued for them.

## Timing
- **Latency:** handshake in cycle t, with both FIFOs otherwise empty, gives `o_rd_wren=1` in cycle t+2. The entry is enqueued at the end of t, granted in t+1, and registered at the end of t+1.
- **Throughput:** one write per cycle sustained. Each source sustains 1/cycle while the other is idle.
- **Simultaneous push and pop** on a non-full FIFO in the same cycle: the count is unchanged and both operations take effect.
- **Both sources saturated:** grant pattern L,L,A repeating (with `STARVE_MAX=2`).
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap naturally. Full/empty come from a separate count of width `$clog2(DEPTH+1)`.

## Structure
- **Package `wb_pkg`:**
  - `localparam XLEN=32`, `localparam REG_AW=5`.
  - `typedef struct packed {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;} wb_req_t`.
- **Sub-module `wb_fifo`:** parameterized on DEPTH and element type `wb_req_t`, with push/pop/full/empty ports. It is instantiated twice, once per source.
- **Top level:** the arbiter, the starvation counter and the output register live in `wb_arbiter`.

## Test plan
- **Single ALU write:** one ALU transfer rd=5, data=0xDEADBEEF in cycle t → `o_rd_wren=1`, `o_rd_addr=5`, `o_rd_data=0xDEADBEEF` in cycle t+2 only; `o_busy` falls in t+3.
- **x0 filter:** LSU transfer rd=0, data=0x12345678 → handshake completes, `o_rd_wren` stays 0, `o_busy` stays 0.
- **Saturation fairness:** both sources valid every cycle with distinct rd (ALU 1..12, LSU 17..28) → write sequence L17,L18,A1,L19,L20,A2…; no result lost or duplicated; per-source order preserved.
- **Backpressure:** LSU valid continuously, ALU pushes rd=3,4,5 back-to-back → `o_alu_ready` drops after 2 ALU accepts. rd=5 is accepted once an ALU grant frees a slot, and retires after rd=3 and rd=4.
- **Reset mid-operation:** both FIFOs full, assert `i_reset` for 1 cycle → outputs 0 immediately, no write of any buffered entry afterward, readies 1 the cycle after release.
- **In-order burst:** 4 ALU transfers rd=6..9, data=0x10..0x13, back-to-back → 4 consecutive writes in cycles t+2..t+5 in the same order.
